fp32_div_seq: RTL and testbench

- Iterative IEEE-754 binary32 divider: result = a / b.
- Inverse operation of the team's combinational single-precision multiplier.
- Uses the same flag set and special-case conventions, plus a div_by_zero flag.
- Multi-cycle (restoring division, one quotient bit per cycle) with valid/ready handshakes on both sides; sits beside the multiplier in the float ALU.

---
 rtl/fp32_pkg.sv | 18 +
 rtl/fp32_round_pack.sv | 52 +++++
 rtl/fp32_div_seq.sv | 149 ++++++++++++++
 tb/tb_fp32_div_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, canonical constants and divider state encoding.
package fp32_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = FRAC_W + 1;
  localparam int unsigned QUO_W   = MANT_W + 2;
  localparam int unsigned SEXP_W  = 10;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, DIV, NORM, HOLD} state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Normalises a raw quotient, rounds to nearest-even and packs a binary32 result
// with overflow/underflow saturation.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic [QUO_W-1:0]         quo,
  input  logic                     rem_nz,
  input  logic signed [SEXP_W-1:0] exp_in,
  input  logic                     sign,
  output logic [31:0]              result,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic signed [SEXP_W-1:0] EXP_TOP = $signed(SEXP_W'(EXP_MAX));

  logic [FRAC_W-1:0]         frac;
  logic [FRAC_W:0]           frac_r;
  logic                      guard;
  logic                      sticky;
  logic                      round_up;
  logic signed [SEXP_W-1:0]  exp_n;
  logic signed [SEXP_W-1:0]  exp_r;

  always_comb begin
    frac      = quo[QUO_W-2:2];
    guard     = quo[1];
    sticky    = quo[0] | rem_nz;
    exp_n     = exp_in;
    overflow  = 1'b0;
    underflow = 1'b0;
    // quotient below 1.0: shift left one place and drop the exponent
    if (!quo[QUO_W-1]) begin
      frac   = quo[QUO_W-3:1];
      guard  = quo[0];
      sticky = rem_nz;
      exp_n  = exp_in - SEXP_W'(1);
    end
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + (FRAC_W+1)'(round_up);
    exp_r    = frac_r[FRAC_W] ? exp_n + SEXP_W'(1) : exp_n;
    result   = {sign, exp_r[EXP_W-1:0], frac_r[FRAC_W-1:0]};
    if (exp_r >= EXP_TOP) begin
      overflow = 1'b1;
      result   = sign ? NEG_INF : POS_INF;
    end else if (exp_r <= SEXP_W'(0)) begin
      underflow = 1'b1;
      result    = {sign, ZERO[30:0]};
    end
  end

endmodule

// File: rtl/fp32_div_seq.sv
// Iterative binary32 divider: restoring division, one quotient bit per cycle,
// valid/ready handshakes on input and output.
module fp32_div_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  localparam int unsigned     CNT_W     = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(QUO_W - 1);

  state_t                    state, state_nx;
  logic [QUO_W-1:0]          rem;
  logic [QUO_W-1:0]          quo;
  logic [MANT_W-1:0]         divisor;
  logic [CNT_W-1:0]          cnt;
  logic signed [SEXP_W-1:0]  exp_q;
  logic                      sign_q;

  logic [EXP_W-1:0]  ea, eb;
  logic              sign_in, special, spec_exc, spec_dbz;
  logic [31:0]       spec_result;
  logic              qbit;
  logic [QUO_W-1:0]  rem_sub;
  logic [31:0]       rp_result;
  logic              rp_ovf, rp_unf;

  assign ea       = a[FRAC_W +: EXP_W];
  assign eb       = b[FRAC_W +: EXP_W];
  assign sign_in  = a[31] ^ b[31];
  assign in_ready = (state == IDLE);

  // special operands are resolved on the accepting edge, in priority order
  always_comb begin
    spec_result = ZERO;
    spec_exc    = 1'b0;
    spec_dbz    = 1'b0;
    special     = 1'b1;
    if (ea == EXP_W'(EXP_MAX) || eb == EXP_W'(EXP_MAX)) begin
      spec_exc = 1'b1;
    end else if (ea == '0 && eb == '0) begin
      spec_exc = 1'b1;
    end else if (ea == '0) begin
      spec_result = {sign_in, ZERO[30:0]};
    end else if (eb == '0) begin
      spec_result = sign_in ? NEG_INF : POS_INF;
      spec_dbz    = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    qbit    = (rem >= QUO_W'(divisor));
    rem_sub = qbit ? rem - QUO_W'(divisor) : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = special ? HOLD : DIV;
      DIV:     if (cnt == LAST_ITER) state_nx = NORM;
      NORM:    state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      exception   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rem     <= QUO_W'({1'b1, a[FRAC_W-1:0]});
          divisor <= {1'b1, b[FRAC_W-1:0]};
          quo     <= '0;
          cnt     <= '0;
          sign_q  <= sign_in;
          exp_q   <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(SEXP_W'(BIAS));
          if (special) begin
            result      <= spec_result;
            exception   <= spec_exc;
            div_by_zero <= spec_dbz;
            out_valid   <= 1'b1;
          end
        end
        DIV: begin
          rem <= {rem_sub[QUO_W-2:0], 1'b0};
          quo <= {quo[QUO_W-2:0], qbit};
          cnt <= cnt + CNT_W'(1);
        end
        NORM: begin
          result    <= rp_result;
          overflow  <= rp_ovf;
          underflow <= rp_unf;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) begin
          out_valid   <= 1'b0;
          exception   <= 1'b0;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  fp32_round_pack u_round_pack (
    .quo       (quo),
    .rem_nz    (rem != '0),
    .exp_in    (exp_q),
    .sign      (sign_q),
    .result    (rp_result),
    .overflow  (rp_ovf),
    .underflow (rp_unf)
  );

endmodule

// File: tb/tb_fp32_div_seq.sv
// Scoreboard bench for fp32_div_seq: directed table plus random operands checked
// against an integer long-division reference model.
module tb_fp32_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        exception, overflow, underflow, div_by_zero;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   manual = 1'b1;
  bit   manual_val = 1'b1;
  bit   checked = 1'b0;

  fp32_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exception(exception), .overflow(overflow),
    .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // consumer: random stalls unless the main thread has taken manual control
  always @(posedge clk) begin
    #2;
    out_ready = manual ? manual_val : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] flags();
    return {exception, overflow, underflow, div_by_zero};
  endfunction

  // reference: exact integer quotient scaled to 25 significant bits, then RNE
  function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    int ea, eb, e;
    longint unsigned ma, mb, num, q, rm, sig;
    bit s, g, st;
    ea = int'(av[30:23]);
    eb = int'(bv[30:23]);
    s  = av[31] ^ bv[31];
    f  = 4'b0000;
    r  = 32'h0;
    lat = 0;
    if (ea == 255 || eb == 255) begin f = 4'b1000; return; end
    if (ea == 0 && eb == 0)     begin f = 4'b1000; return; end
    if (ea == 0)                begin r = {s, 31'h0}; return; end
    if (eb == 0)                begin r = {s, 8'hFF, 23'h0}; f = 4'b0001; return; end
    lat = 27;
    ma = {40'd0, 1'b1, av[22:0]};
    mb = {40'd0, 1'b1, bv[22:0]};
    e  = ea - eb + 127;
    if (ma >= mb) num = ma << 24;
    else begin num = ma << 25; e = e - 1; end
    q   = num / mb;
    rm  = num % mb;
    sig = q >> 1;
    g   = q[0];
    st  = (rm != 0);
    if (g && (st || sig[0])) sig = sig + 1;
    if (sig == (64'd1 << 24)) begin sig = 64'd1 << 23; e = e + 1; end
    if (e >= 255)   begin r = {s, 8'hFF, 23'h0}; f = 4'b0100; end
    else if (e <= 0) begin r = {s, 31'h0}; f = 4'b0010; end
    else r = {s, 8'(e), sig[22:0]};
  endfunction

  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] r, input logic [3:0] f, input int lat);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout a=%h b=%h in_ready=%b want 1", av, bv, in_ready);
      return;
    end
    e.a = av; e.b = bv; e.r = r; e.f = f; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    model(av, bv, r, f, lat);
    send(av, bv, r, f, lat);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin @(negedge clk); n++; end
    if (sb.size() != 0 || out_valid) begin
      tests++; fails++;
      $display("FAIL drain_timeout pending=%0d out_valid=%b want 0/0", sb.size(), out_valid);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int k;
    k = $urandom_range(0, 19);
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k < 12) e = 8'($urandom_range(100, 154));
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // monitor: compare on the first cycle of each out_valid window
  always @(negedge clk) begin
    if (!out_valid) checked = 1'b0;
    else if (!checked) begin
      checked = 1'b1;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output result=%h want no output", result);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("result %h/%h", mon_e.a, mon_e.b), result, mon_e.r);
        chk($sformatf("flags %h/%h", mon_e.a, mon_e.b), 32'(flags()), 32'(mon_e.f));
        chk($sformatf("latency %h/%h", mon_e.a, mon_e.b), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", result, 32'h0);
    chk("reset_flags", 32'(flags()), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases with hand-derived expectations; flags = {exc,ovf,unf,dbz}
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    send(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 27);
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27);
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 27);
    send(32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 27);
    send(32'h00800000, 32'h7F000000, 32'h00000000, 4'b0010, 27);
    send(32'hC0000000, 32'h00000000, 32'hFF800000, 4'b0001, 0);
    send(32'h7FC00000, 32'h3F800000, 32'h00000000, 4'b1000, 0);
    send(32'h00000000, 32'h00000000, 32'h00000000, 4'b1000, 0);
    send(32'h00000000, 32'h40000000, 32'h00000000, 4'b0000, 0);
    send(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 0);
    send(32'h7F800000, 32'h00000000, 32'h00000000, 4'b1000, 0);
    drain();

    // backpressure: result held, input side closed, stray in_valid ignored
    manual_val = 1'b0;
    @(negedge clk);
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_result_hold", result, 32'h40400000);
      chk("bp_flags_hold", 32'(flags()), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      a = $urandom; b = $urandom; in_valid = 1'(i % 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    manual_val = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_released_valid", 32'(out_valid), 32'd0);
    chk("bp_released_ready", 32'(in_ready), 32'd1);
    drain();

    // reset while dividing aborts the operation
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    drain();

    // random operands with random consumer stalls
    manual = 1'b0;
    for (int i = 0; i < 40; i++) send_model(rand_op(), rand_op());
    drain();
    manual = 1'b1;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
